// File: rtl/avalon_pkg.sv
// Shared types and defaults for the Avalon-MM scratch responder
// and anything that talks to it.
package avalon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCEPT = 2'd2
    } av_state_e;

    localparam int CNT_W     = 4;
    localparam int AV_ADDR_W = 4;
    localparam int AV_DATA_W = 4;

endpackage

// File: rtl/avalon_mem_responder_if.sv
// Avalon-MM read/write/waitrequest/readdatavalid bundle.
interface avalon_mem_responder_if
    import avalon_pkg::*;
#(
    parameter int ADDR_W = AV_ADDR_W,
    parameter int DATA_W = AV_DATA_W
);

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic              readdatavalid;
    logic [DATA_W-1:0] readdata;
    logic              protocol_err;

    modport master (
        output address, read, write, writedata,
        input  waitrequest, readdatavalid, readdata, protocol_err
    );

    modport slave (
        input  address, read, write, writedata,
        output waitrequest, readdatavalid, readdata, protocol_err
    );

endinterface

// File: rtl/avalon_read_pipe.sv
// Fixed-latency valid+data shift register carrying read returns;
// every stage is independent so reads may overlap in flight.
module avalon_read_pipe #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [DEPTH];
    logic [DATA_W-1:0] dat_d [DEPTH];

    always_comb begin
        vld_d[0] = in_valid;
        dat_d[0] = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= dat_d[i];
        end
    end

    assign out_valid = vld_q[DEPTH-1];
    assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM scratch memory slave with programmable wait states
// and pipelined, fixed-latency read returns.
module avalon_mem_responder
    import avalon_pkg::*;
#(
    parameter int ADDR_W       = AV_ADDR_W,
    parameter int DATA_W       = AV_DATA_W,
    parameter int WAIT_STATES  = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset_n,
    avalon_mem_responder_if.slave bus
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] WAIT   = ST_WAIT;
    localparam logic [1:0] ACCEPT = ST_ACCEPT;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rdv_q, rdv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              req;
    logic              acc_wr;
    logic              acc_rd;
    logic              pipe_vld;
    logic [DATA_W-1:0] pipe_dat;

    assign req = bus.read | bus.write;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        acc_wr  = 1'b0;
        acc_rd  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES);
                end
            end
            WAIT: begin
                if (!req) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                state_d = IDLE;
                // read+write together resolves to a write and is flagged
                if (!req || (bus.read && bus.write)) err_d = 1'b1;
                acc_wr = bus.write;
                acc_rd = bus.read & ~bus.write;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdv_d   = pipe_vld;
        rdata_d = pipe_vld ? pipe_dat : rdata_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdv_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdv_q   <= rdv_d;
            rdata_q <= rdata_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (acc_wr) mem_q[bus.address] <= bus.writedata;
    end

    avalon_read_pipe #(
        .DEPTH  (READ_LATENCY),
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk       (clock),
        .rst_n     (reset_n),
        .in_valid  (acc_rd),
        .in_data   (mem_q[bus.address]),
        .out_valid (pipe_vld),
        .out_data  (pipe_dat)
    );

    assign bus.waitrequest   = (state_q != ACCEPT);
    assign bus.readdatavalid = rdv_q;
    assign bus.readdata      = rdata_q;
    assign bus.protocol_err  = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: two instances (default timing and
// zero-wait/latency-3) checked against an accept-edge level model.
module tb_avalon_mem_responder;
    import avalon_pkg::*;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    logic       sel;
    logic       m_read, m_write;
    logic [3:0] m_addr, m_wdata;

    avalon_mem_responder_if #(.ADDR_W(4), .DATA_W(4)) bus0 ();
    avalon_mem_responder_if #(.ADDR_W(4), .DATA_W(4)) bus1 ();

    assign bus0.read      = !sel && m_read;
    assign bus0.write     = !sel && m_write;
    assign bus0.address   = m_addr;
    assign bus0.writedata = m_wdata;
    assign bus1.read      = sel && m_read;
    assign bus1.write     = sel && m_write;
    assign bus1.address   = m_addr;
    assign bus1.writedata = m_wdata;

    avalon_mem_responder #(
        .ADDR_W(4), .DATA_W(4), .WAIT_STATES(3), .READ_LATENCY(1)
    ) dut0 (.clock(clk), .reset_n(rst_n), .bus(bus0));

    avalon_mem_responder #(
        .ADDR_W(4), .DATA_W(4), .WAIT_STATES(0), .READ_LATENCY(3)
    ) dut1 (.clock(clk), .reset_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int rst_cnt = 0;
    int rst_seen = 0;
    always @(negedge rst_n) rst_cnt <= rst_cnt + 1;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    // ---------------- model: accept edges, memory, returns ----------------
    int         ws [2] = '{3, 0};
    int         rl [2] = '{1, 3};
    logic       busy [2];
    int         acc_e [2];
    logic       err_e [2];
    logic       rdv_e [2];
    logic [3:0] rd_e [2];
    logic       rd_k [2];
    logic [3:0] mm [2][16];
    logic       mk [2][16];
    logic       pv [2][16];
    logic [3:0] pd [2][16];
    logic       pk [2][16];

    function automatic logic in_rd(input int d);
        return d == 0 ? bus0.read : bus1.read;
    endfunction
    function automatic logic in_wr(input int d);
        return d == 0 ? bus0.write : bus1.write;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 2; d++) begin
            busy[d] = 1'b0; err_e[d] = 1'b0; rdv_e[d] = 1'b0;
            rd_e[d] = 4'd0; rd_k[d] = 1'b1; acc_e[d] = -10;
            for (int i = 0; i < 16; i++) pv[d][i] = 1'b0;
        end
    endtask

    task automatic m_step(input int d, input int n);
        logic rd, wr;
        int   s;
        rd = in_rd(d);
        wr = in_wr(d);
        rdv_e[d] = pv[d][n % 16];
        if (pv[d][n % 16]) begin
            rd_e[d] = pd[d][n % 16];
            rd_k[d] = pk[d][n % 16];
            pv[d][n % 16] = 1'b0;
        end
        if (!busy[d]) begin
            if (rd || wr) begin
                busy[d] = 1'b1;
                acc_e[d] = n + ws[d] + 2;
            end
        end else if (n == acc_e[d]) begin
            busy[d] = 1'b0;
            if (!(rd || wr)) err_e[d] = 1'b1;
            else if (wr) begin
                mm[d][m_addr] = m_wdata;
                mk[d][m_addr] = 1'b1;
                if (rd) err_e[d] = 1'b1;
            end else begin
                s = (n + rl[d]) % 16;
                pv[d][s] = 1'b1;
                pd[d][s] = mm[d][m_addr];
                pk[d][s] = mk[d][m_addr];
            end
        end else if (!(rd || wr)) begin
            busy[d] = 1'b0;
            err_e[d] = 1'b1;
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) mk[d][i] = 1'b0;
        m_reset();
        forever begin
            @(clk);
            if (rst_cnt != rst_seen || !rst_n) begin
                rst_seen = rst_cnt;
                m_reset();
            end else if (clk) begin
                for (int d = 0; d < 2; d++) m_step(d, cyc + 1);
            end
            if (!clk) begin
                check("wreq0", bus0.waitrequest, !(busy[0] && acc_e[0] == cyc + 1));
                check("wreq1", bus1.waitrequest, !(busy[1] && acc_e[1] == cyc + 1));
                check("rdv0", bus0.readdatavalid, rdv_e[0]);
                check("rdv1", bus1.readdatavalid, rdv_e[1]);
                check("err0", bus0.protocol_err, err_e[0]);
                check("err1", bus1.protocol_err, err_e[1]);
                if (rd_k[0]) check("rdata0", bus0.readdata, rd_e[0]);
                if (rd_k[1]) check("rdata1", bus1.readdata, rd_e[1]);
            end
        end
    end

    // ---------------- return monitor for the latency-3 instance ----------
    logic [3:0] cap_d [8];
    int         cap_e [8];
    int         n_cap = 0;
    always @(negedge clk) begin
        if (bus1.readdatavalid && n_cap < 8) begin
            cap_d[n_cap] <= bus1.readdata;
            cap_e[n_cap] <= cyc;
            n_cap <= n_cap + 1;
        end
    end

    // ---------------- master-side tasks (enter/leave at posedge+1) -------
    function automatic logic cur_wreq();
        return sel ? bus1.waitrequest : bus0.waitrequest;
    endfunction

    task automatic idle();
        m_read = 1'b0;
        m_write = 1'b0;
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [3:0] a,
                          input logic [3:0] d, output int k, output int acc);
        logic got;
        got = 1'b0;
        m_read = rd; m_write = wr; m_addr = a; m_wdata = d;
        k = cyc + 1;
        acc = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (!cur_wreq()) begin
                @(posedge clk);
                #1;
                acc = cyc;
                got = 1'b1;
            end
        end
        check("accept_seen", got, 1'b1);
    endtask

    task automatic wait_rdv(output logic [3:0] data, output int e);
        logic got;
        got = 1'b0;
        data = 4'd0;
        e = -1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus0.readdatavalid) begin
                data = bus0.readdata;
                e = cyc;
                got = 1'b1;
            end
        end
        check("rdv_seen", got, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic read_chk(input string nm, input logic [3:0] a, input logic [3:0] exp);
        int k, acc, e;
        logic [3:0] d;
        do_req(1'b1, 1'b0, a, 4'd0, k, acc);
        idle();
        wait_rdv(d, e);
        check(nm, d, exp);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k, a, e;
        int acc_r [8];
        logic [3:0] d;
        n_tests = 0;
        n_fail = 0;
        sel = 1'b0;
        m_read = 1'b1; m_write = 1'b0; m_addr = 4'd0; m_wdata = 4'd0;
        rst_n = 1'b0;

        // 1: reset values with read held, then the read proceeds
        repeat (3) @(posedge clk);
        #1;
        check("t1_rst_wreq", bus0.waitrequest, 1'b1);
        check("t1_rst_rdv", bus0.readdatavalid, 1'b0);
        check("t1_rst_rdata", bus0.readdata, 4'd0);
        check("t1_rst_err", bus0.protocol_err, 1'b0);
        rst_n = 1'b1;
        do_req(1'b1, 1'b0, 4'd0, 4'd0, k, a);
        idle();
        check("t1_latency", a - k, 5);
        wait_rdv(d, e);
        check("t1_rdv_lat", e - a, 1);

        // 2: write 2 <- 9
        do_req(1'b0, 1'b1, 4'd2, 4'd9, k, a);
        idle();
        check("t2_latency", a - k, 5);

        // 3: read 2 -> 9 one cycle after accept, then held
        do_req(1'b1, 1'b0, 4'd2, 4'd0, k, a);
        idle();
        check("t3_latency", a - k, 5);
        wait_rdv(d, e);
        check("t3_rdv_lat", e - a, 1);
        check("t3_data", d, 4'd9);
        repeat (3) @(negedge clk);
        check("t3_hold", bus0.readdata, 4'd9);
        @(posedge clk);
        #1;

        // 5a: read+write together behaves as a flagged write
        check("t5_err_before", bus0.protocol_err, 1'b0);
        do_req(1'b1, 1'b1, 4'd5, 4'd7, k, a);
        idle();
        @(negedge clk);
        check("t5_err_both", bus0.protocol_err, 1'b1);
        @(posedge clk);
        #1;
        read_chk("t5_read5", 4'd5, 4'd7);

        // 5b: fresh run, write abandoned during wait
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t5_err_cleared", bus0.protocol_err, 1'b0);
        m_write = 1'b1; m_addr = 4'd5; m_wdata = 4'd1;
        repeat (2) @(posedge clk);
        #1;
        idle();
        @(posedge clk);
        #1;
        check("t5_err_abandon", bus0.protocol_err, 1'b1);
        read_chk("t5_mem_kept", 4'd5, 4'd7);

        // 6: reset in the middle of a write
        do_req(1'b0, 1'b1, 4'd3, 4'd6, k, a);
        idle();
        m_write = 1'b1; m_addr = 4'd3; m_wdata = 4'd12;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        idle();
        #1;
        check("t6_async_wreq", bus0.waitrequest, 1'b1);
        check("t6_async_err", bus0.protocol_err, 1'b0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_chk("t6_read3", 4'd3, 4'd6);

        // 4: zero wait states, latency 3, overlapping reads
        sel = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, 1'b1, 4'(i), 4'(i + 1), k, acc_r[i]);
            if (i == 0) check("t4_wr_latency", acc_r[0] - k, 2);
        end
        for (int i = 0; i < 4; i++)
            do_req(1'b1, 1'b0, 4'(i), 4'd0, k, acc_r[4 + i]);
        idle();
        repeat (10) @(posedge clk);
        #1;
        check("t4_count", n_cap, 4);
        for (int i = 0; i < 4; i++) begin
            check("t4_data", cap_d[i], 4'(i + 1));
            check("t4_lat", cap_e[i] - acc_r[4 + i], 3);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
